// File: rtl/switch_egress_port.sv
// Egress port: credit-gated admission into a small flit FIFO that feeds the link,
// plus a packet tracker that pulses packet_sent as each tail flit leaves.
package switch_egress_pkg;
    localparam int VC_W = 4;

    typedef struct packed {
        logic [VC_W-1:0] vc;
        logic [31:0]     payload;
    } flit_t;
endpackage

// state | meaning
// IDLE  | next pop is a head flit; its length field is decoded
// BODY  | popping body flits; remaining_q counts the ones still owed
module switch_egress_port
    import switch_egress_pkg::*;
#(
    parameter int NUM_VCS    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDIT_MAX = 8,
    parameter int LEN_LSB    = 0,
    parameter int LEN_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_ready_in,
    input  flit_t              in,
    output logic [NUM_VCS-1:0] buffer_available,
    output logic               link_valid,
    output flit_t              link_flit,
    input  logic               link_ready,
    input  logic [NUM_VCS-1:0] credit_return,
    output logic               packet_sent,
    output logic               err_overflow,
    output logic               err_credit
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = $clog2(CREDIT_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CRD_W-1:0] CRD_MAX_C = CRD_W'(CREDIT_MAX);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    flit_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CRD_W-1:0] credits_q [NUM_VCS];
    logic [CRD_W-1:0] credits_d [NUM_VCS];
    logic [0:0]       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d, head_len;
    logic             packet_sent_q, err_overflow_q, err_credit_q;
    logic             credit_ok, accept, drop, pop, tail, credit_err;

    assign link_valid   = (count_q != '0);
    assign link_flit    = mem_q[rd_ptr_q];
    assign pop          = link_valid && link_ready;
    assign packet_sent  = packet_sent_q;
    assign err_overflow = err_overflow_q;
    assign err_credit   = err_credit_q;
    assign head_len     = link_flit.payload[LEN_LSB +: LEN_W];

    always_comb begin
        credit_ok = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (in.vc == VC_W'(v) && credits_q[v] != '0) credit_ok = 1'b1;
            buffer_available[v] = (credits_q[v] != '0) && (count_q != DEPTH_C);
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still take a flit.
    assign accept = data_ready_in && credit_ok && ((count_q != DEPTH_C) || pop);
    assign drop   = data_ready_in && !accept;

    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + 1'b1;
        else if (!accept && pop) count_d = count_q - 1'b1;
    end

    always_comb begin
        credit_err = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            credits_d[v] = credits_q[v];
            if (credit_return[v] && !(accept && in.vc == VC_W'(v))) begin
                if (credits_q[v] == CRD_MAX_C) credit_err = 1'b1;
                else                           credits_d[v] = credits_q[v] + 1'b1;
            end else if (!credit_return[v] && accept && in.vc == VC_W'(v)) begin
                credits_d[v] = credits_q[v] - 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tail        = 1'b0;
        if (pop) begin
            if (state_q == ST_IDLE) begin
                if (head_len == '0) begin
                    tail = 1'b1;
                end else begin
                    remaining_d = head_len;
                    state_d     = ST_BODY;
                end
            end else begin
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == LEN_W'(1)) begin
                    tail    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // Storage is not reset; link_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            state_q        <= ST_IDLE;
            remaining_q    <= '0;
            packet_sent_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            err_credit_q   <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) credits_q[v] <= CRD_MAX_C;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q       <= count_d;
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            packet_sent_q <= tail;
            if (drop)       err_overflow_q <= 1'b1;
            if (credit_err) err_credit_q   <= 1'b1;
            for (int v = 0; v < NUM_VCS; v++) credits_q[v] <= credits_d[v];
        end
    end

endmodule

// File: tb/tb_switch_egress_port.sv
// Directed bench for switch_egress_port: hand-computed expectations for latency,
// stalls, credit exhaustion, full-FIFO push/pop, credit errors and mid-packet reset.
module tb_switch_egress_port;
    import switch_egress_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_ready_in;
    flit_t      in_flit;
    logic [1:0] buffer_available;
    logic       link_valid;
    flit_t      link_flit;
    logic       link_ready;
    logic [1:0] credit_return;
    logic       packet_sent;
    logic       err_overflow;
    logic       err_credit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_egress_port dut (
        .clk              (clk),
        .rst              (rst),
        .data_ready_in    (data_ready_in),
        .in               (in_flit),
        .buffer_available (buffer_available),
        .link_valid       (link_valid),
        .link_flit        (link_flit),
        .link_ready       (link_ready),
        .credit_return    (credit_return),
        .packet_sent      (packet_sent),
        .err_overflow     (err_overflow),
        .err_credit       (err_credit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        data_ready_in = 1'b0;
        credit_return = 2'b00;
    endtask

    task automatic put(input logic [3:0] vc, input logic [31:0] pl);
        data_ready_in   = 1'b1;
        in_flit.vc      = vc;
        in_flit.payload = pl;
    endtask

    task automatic do_reset(input string tag);
        rst        = 1'b1;
        link_ready = 1'b0;
        idle_in();
        step();
        step();
        chk({tag, "_rst_valid"}, 32'(link_valid), 32'd0);
        chk({tag, "_rst_avail"}, 32'(buffer_available), 32'h3);
        chk({tag, "_rst_errs"}, 32'({packet_sent, err_overflow, err_credit}), 32'd0);
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst     = 1'b1;
        in_flit = '0;
        idle_in();
        link_ready = 1'b0;

        // single zero-length head on vc0
        do_reset("t1");
        chk("t1_credit_init", 32'(dut.credits_q[0]), 32'd8);
        link_ready = 1'b1;
        put(4'd0, 32'h0000_AB00);
        step();
        idle_in();
        chk("t1_valid", 32'(link_valid), 32'd1);
        chk("t1_payload", link_flit.payload, 32'h0000_AB00);
        chk("t1_vc", 32'(link_flit.vc), 32'd0);
        chk("t1_no_early_sent", 32'(packet_sent), 32'd0);
        chk("t1_credit", 32'(dut.credits_q[0]), 32'd7);
        step();
        chk("t1_sent", 32'(packet_sent), 32'd1);
        chk("t1_empty", 32'(link_valid), 32'd0);
        step();
        chk("t1_sent_pulse", 32'(packet_sent), 32'd0);
        credit_return = 2'b01;
        step();
        credit_return = 2'b00;
        chk("t1_credit_back", 32'(dut.credits_q[0]), 32'd8);

        // head L=2 plus two bodies, stalled then drained
        link_ready = 1'b0;
        put(4'd0, 32'h0000_1102);
        step();
        chk("t2_head_valid", 32'(link_valid), 32'd1);
        chk("t2_head", link_flit.payload, 32'h0000_1102);
        put(4'd0, 32'h0000_B100);
        step();
        chk("t2_stall1", link_flit.payload, 32'h0000_1102);
        put(4'd0, 32'h0000_B200);
        step();
        idle_in();
        chk("t2_stall2", link_flit.payload, 32'h0000_1102);
        chk("t2_credit", 32'(dut.credits_q[0]), 32'd5);
        step();
        chk("t2_stall3", link_flit.payload, 32'h0000_1102);
        chk("t2_stall_ps", 32'(packet_sent), 32'd0);
        link_ready = 1'b1;
        step();
        chk("t2_body1", link_flit.payload, 32'h0000_B100);
        chk("t2_body1_ps", 32'(packet_sent), 32'd0);
        step();
        chk("t2_body2", link_flit.payload, 32'h0000_B200);
        chk("t2_body2_ps", 32'(packet_sent), 32'd0);
        step();
        chk("t2_tail_ps", 32'(packet_sent), 32'd1);
        chk("t2_drained", 32'(link_valid), 32'd0);
        step();
        chk("t2_one_pulse", 32'(packet_sent), 32'd0);
        for (int i = 0; i < 3; i++) begin
            credit_return = 2'b01;
            step();
        end
        credit_return = 2'b00;
        chk("t2_credit_back", 32'(dut.credits_q[0]), 32'd8);

        // exhaust vc1 credits
        link_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(4'd1, 32'h0001_0000 | (32'(i) << 8));
            step();
            if (i == 2) chk("t3_ps_a", 32'(packet_sent), 32'd1);
            if (i == 3) chk("t3_ps_b", 32'(packet_sent), 32'd1);
        end
        chk("t3_avail", 32'(buffer_available), 32'h1);
        chk("t3_credit1", 32'(dut.credits_q[1]), 32'd0);
        chk("t3_no_err_yet", 32'(err_overflow), 32'd0);
        put(4'd1, 32'h0009_0000);
        step();
        idle_in();
        chk("t3_drop_err", 32'(err_overflow), 32'd1);
        chk("t3_drop_credit", 32'(dut.credits_q[1]), 32'd0);
        chk("t3_drop_not_queued", 32'(link_valid), 32'd0);
        step();
        step();
        chk("t3_sticky", 32'(err_overflow), 32'd1);

        // full FIFO, push with pop, push without pop
        do_reset("t4");
        put(4'd0, 32'h0000_4100);
        step();
        put(4'd1, 32'h0000_4200);
        step();
        put(4'd0, 32'h0000_4300);
        step();
        put(4'd1, 32'h0000_4400);
        step();
        idle_in();
        chk("t4_full_avail", 32'(buffer_available), 32'h0);
        chk("t4_full_count", 32'(dut.count_q), 32'd4);
        chk("t4_full_head", link_flit.payload, 32'h0000_4100);
        put(4'd0, 32'h0000_4500);
        link_ready = 1'b1;
        step();
        idle_in();
        link_ready = 1'b0;
        chk("t4_pushpop_count", 32'(dut.count_q), 32'd4);
        chk("t4_pushpop_err", 32'(err_overflow), 32'd0);
        chk("t4_pushpop_head", link_flit.payload, 32'h0000_4200);
        chk("t4_pushpop_credit", 32'(dut.credits_q[0]), 32'd5);
        put(4'd1, 32'h0000_4600);
        step();
        idle_in();
        chk("t4_full_drop_err", 32'(err_overflow), 32'd1);
        chk("t4_full_drop_count", 32'(dut.count_q), 32'd4);
        chk("t4_full_drop_credit", 32'(dut.credits_q[1]), 32'd6);

        // credit return at max, return plus accept
        do_reset("t5");
        credit_return = 2'b01;
        step();
        credit_return = 2'b00;
        chk("t5_err_credit", 32'(err_credit), 32'd1);
        chk("t5_credit_held", 32'(dut.credits_q[0]), 32'd8);
        put(4'd0, 32'h0000_5100);
        step();
        chk("t5_credit_dec", 32'(dut.credits_q[0]), 32'd7);
        put(4'd0, 32'h0000_5200);
        credit_return = 2'b01;
        step();
        idle_in();
        chk("t5_same_cycle", 32'(dut.credits_q[0]), 32'd7);
        chk("t5_same_cycle_count", 32'(dut.count_q), 32'd2);
        step();
        chk("t5_sticky", 32'(err_credit), 32'd1);

        // reset in the middle of a packet
        do_reset("t6");
        put(4'd0, 32'h0000_6105);
        step();
        put(4'd1, 32'h0000_6200);
        step();
        put(4'd0, 32'h0000_6300);
        step();
        put(4'd1, 32'h0000_6400);
        step();
        idle_in();
        link_ready = 1'b1;
        step();
        link_ready = 1'b0;
        chk("t6_in_body", 32'(dut.remaining_q), 32'd5);
        chk("t6_queued", 32'(dut.count_q), 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(link_valid), 32'd0);
        chk("t6_rst_avail", 32'(buffer_available), 32'h3);
        chk("t6_rst_credit0", 32'(dut.credits_q[0]), 32'd8);
        chk("t6_rst_credit1", 32'(dut.credits_q[1]), 32'd8);
        step();
        chk("t6_rst_ps1", 32'(packet_sent), 32'd0);
        step();
        chk("t6_rst_ps2", 32'(packet_sent), 32'd0);
        rst = 1'b0;
        step();
        chk("t6_post_ps", 32'(packet_sent), 32'd0);
        chk("t6_post_valid", 32'(link_valid), 32'd0);
        link_ready = 1'b1;
        put(4'd1, 32'h0000_6500);
        step();
        idle_in();
        chk("t6_resume_valid", 32'(link_valid), 32'd1);
        chk("t6_resume_payload", link_flit.payload, 32'h0000_6500);
        step();
        chk("t6_resume_sent", 32'(packet_sent), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
